// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO registers for the E stage.
// The result is computed at issue and held until the latency counter
// expires, so HI/LO only change on the commit edge.
module md_unit #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned PROD_W  = 2 * WIDTH;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic [WIDTH-1:0]   r_hi, w_hi_nxt;
   logic [WIDTH-1:0]   r_lo, w_lo_nxt;
   logic [WIDTH-1:0]   r_res_hi, w_res_hi_nxt;
   logic [WIDTH-1:0]   r_res_lo, w_res_lo_nxt;

   logic [PROD_W-1:0]  w_a_sext, w_b_sext, w_a_zext, w_b_zext;
   logic [PROD_W-1:0]  w_prod_s, w_prod_u;
   logic [WIDTH-1:0]   w_min;
   logic               w_div_zero, w_div_ovf;
   logic [WIDTH-1:0]   w_q_s, w_r_s, w_q_u, w_r_u;
   logic [WIDTH-1:0]   w_calc_hi, w_calc_lo;

   // Full-width products: operands extended to 2*WIDTH so low 2*WIDTH bits are exact
   assign w_a_sext = {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
   assign w_b_sext = {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
   assign w_a_zext = {WIDTH'(0), rs_val};
   assign w_b_zext = {WIDTH'(0), rt_val};
   assign w_prod_s = w_a_sext * w_b_sext;
   assign w_prod_u = w_a_zext * w_b_zext;

   // Quotient/remainder; zero divisor and signed overflow are overridden below
   assign w_min      = {1'b1, {(WIDTH-1){1'b0}}};
   assign w_div_zero = (rt_val == '0);
   assign w_div_ovf  = (rs_val == w_min) && (rt_val == '1);
   assign w_q_s      = WIDTH'($signed(rs_val) / $signed(rt_val));
   assign w_r_s      = WIDTH'($signed(rs_val) % $signed(rt_val));
   assign w_q_u      = rs_val / rt_val;
   assign w_r_u      = rs_val % rt_val;

   // Result select for the operation being issued
   always_comb begin
      w_calc_hi = w_prod_s[PROD_W-1:WIDTH];
      w_calc_lo = w_prod_s[WIDTH-1:0];
      case (op)
         OP_MULTU: begin
            w_calc_hi = w_prod_u[PROD_W-1:WIDTH];
            w_calc_lo = w_prod_u[WIDTH-1:0];
         end
         OP_DIV: begin
            if (w_div_zero) begin
               w_calc_hi = rs_val;
               w_calc_lo = '1;
            end else if (w_div_ovf) begin
               w_calc_hi = '0;
               w_calc_lo = w_min;
            end else begin
               w_calc_hi = w_r_s;
               w_calc_lo = w_q_s;
            end
         end
         OP_DIVU: begin
            if (w_div_zero) begin
               w_calc_hi = rs_val;
               w_calc_lo = '1;
            end else begin
               w_calc_hi = w_r_u;
               w_calc_lo = w_q_u;
            end
         end
         default: ;
      endcase
   end

   // Next-state and registered-output logic; cancel outranks start and completion
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_res_hi_nxt = r_res_hi;
      w_res_lo_nxt = r_res_lo;
      case (r_state)
         S_IDLE: begin
            w_busy_nxt = 1'b0;
            if (start && !cancel) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     w_res_hi_nxt = w_calc_hi;
                     w_res_lo_nxt = w_calc_lo;
                     w_cnt_nxt    = CNT_W'(MUL_CYCLES);
                     w_busy_nxt   = 1'b1;
                     w_state_nxt  = S_RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     w_res_hi_nxt = w_calc_hi;
                     w_res_lo_nxt = w_calc_lo;
                     w_cnt_nxt    = CNT_W'(DIV_CYCLES);
                     w_busy_nxt   = 1'b1;
                     w_state_nxt  = S_RUN;
                  end
                  OP_MTHI: w_hi_nxt = rs_val;
                  OP_MTLO: w_lo_nxt = rs_val;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (cancel) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_W'(1)) begin
               w_hi_nxt    = r_res_hi;
               w_lo_nxt    = r_res_lo;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_res_hi <= '0;
         r_res_lo <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_res_hi <= w_res_hi_nxt;
         r_res_lo <= w_res_lo_nxt;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
